serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that time-shares one full-adder cell, built from two `HA` half-adder instances plus an OR gate for carry, across all bit positions of a WIDTH-bit addition. It accepts a start request with two operands, then steps the shared cell LSB-first for WIDTH cycles. A carry flip-flop links each bit to the next. The result is presented with a one-cycle done pulse. It sits between the lab's operand source (switches or testbench) and the half-adder datapath, and is the first clocked block in the adder series.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while bits are being processed (state ADD).
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out of the MSB; held with sum.

## Operation

- States: IDLE, ADD, DONE. Encoding is free; no illegal-state lockup is allowed, so any undefined state returns to IDLE.
- IDLE with start=1 at an edge:
  - load shift registers ra←a and rb←b;
  - clear the carry flop c←0 and the bit counter cnt←0;
  - go to ADD.
- ADD, each edge:
  - The shared cell computes s = ra[0]^rb[0]^c and co = (ra[0]&rb[0]) | (c&(ra[0]^rb[0])) via the two HA instances.
  - s shifts into the MSB of the result shift register rs, and rs shifts right.
  - ra and rb shift right. c←co. cnt←cnt+1.
  - When cnt = WIDTH-1 at the edge, the final bit is processed: sum←{s, rs[WIDTH-1:1]}, cout←co, and the state goes to DONE.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- start is ignored in ADD and DONE, and a/b changes outside the accepting edge have no effect.
- If start is held high continuously, a new operation is accepted on the first edge in IDLE, i.e. one idle cycle between operations.
- cnt width is clog2(WIDTH); WIDTH must not be exceeded and cnt does not wrap.
- Arithmetic is unsigned modulo 2^WIDTH, with overflow reported only on cout.

## Timing

- Reset (asynchronous assert, synchronous-safe release): state=IDLE, busy=0, done=0, sum=0, cout=0, ra/rb/rs/c/cnt=0.
- Reset asserted mid-ADD aborts the operation. sum/cout are forced to 0, not the previous result.
- Edge E0 accepts start; busy=1 from E0 through E_WIDTH.
- Edge E_WIDTH loads sum/cout, drops busy and raises done.
- Edge E_WIDTH+1 drops done and returns to IDLE.
- Latency from the accepting edge to done is WIDTH cycles. Throughput is one addition per WIDTH+2 cycles.
- sum/cout keep the previous result throughout a new operation and change only on the completing edge.
- busy and done are never high together.

## Test plan

- Reset then idle: rst_n low for 3 cycles → busy=0, done=0, sum=0x00, cout=0, with no done pulse for 20 cycles while start=0.
- Basic add, WIDTH=8: a=0xA5, b=0x5A, start pulse → busy high for 8 cycles, then done pulse, sum=0xFF, cout=0.
- Full carry ripple: a=0xFF, b=0x01 → sum=0x00, cout=1, with done exactly 8 edges after the accepting edge.
- Start/operand changes while busy: start a=0x0F, b=0x01; at cycle 3 assert start with a=0xFF, b=0xFF → result sum=0x10, cout=0, and only one done pulse.
- Reset mid-operation: previous result 0x10; start a=0x80, b=0x80; pull rst_n low at cycle 4 → sum=0x00, cout=0, busy=0, and no done pulse after release.
- Back-to-back: start held high with a=0x01, b=0x01 → done pulses every 10 cycles, sum=0x02 each time, one IDLE cycle between operations.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl (with helper cell ha)
// Description : Bit-serial adder controller. One full-adder cell, built from
//               two half-adder instances and an OR gate for the carry, is
//               shared across all bit positions. The cell is stepped LSB-first
//               for WIDTH cycles, and a carry flop links each bit to the next.
//               The result is registered and flagged by a one-cycle done pulse.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               start  - begin an addition (sampled only in IDLE)
//               a, b   - WIDTH-bit operands, captured on the accepting edge
//               busy   - high while bits are being processed (ADD)
//               done   - one-cycle completion pulse
//               sum    - registered WIDTH-bit result, held until next completion
//               cout   - registered MSB carry-out, held with sum
// Revision    : 1.0 - initial release
// ============================================================================

module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    // Only WIDTH-1 partial bits need storing: the final bit goes straight
    // from the cell into the result register on the completing edge.
    logic [WIDTH-2:0] r_rs;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_p;
    logic             w_g;
    logic             w_s;
    logic             w_pc;
    logic             w_co;
    logic [WIDTH-1:0] w_rs_full;
    logic             w_accept;
    logic             w_last;

    // Shared full-adder cell: propagate/generate, then fold in the carry.
    ha u_ha0 (
        .x (r_ra[0]),
        .y (r_rb[0]),
        .s (w_p),
        .c (w_g)
    );

    ha u_ha1 (
        .x (w_p),
        .y (r_c),
        .s (w_s),
        .c (w_pc)
    );

    assign w_co      = w_g | w_pc;
    assign w_rs_full = {w_s, r_rs};
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_ADD) && (r_cnt == C_LAST_BIT);

    assign busy = (r_state == S_ADD);
    assign done = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; any unencoded state falls back to IDLE.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = start  ? S_ADD  : S_IDLE;
            S_ADD:   w_state_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand/result shift registers, carry flop, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_rs  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= a;
            r_rb  <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_ADD) begin
            r_ra <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb <= {1'b0, r_rb[WIDTH-1:1]};
            r_rs <= w_rs_full[WIDTH-1:1];
            r_c  <= w_co;
            if (w_last) begin
                // Counter stops at the last bit rather than wrapping.
                sum  <= w_rs_full;
                cout <= w_co;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_vec;
    int n_err;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one addition from IDLE and follow it to completion.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] prev_sum);
        int lat;
        a = op_a; b = op_b; start = 1'b1;
        tick;
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        lat = 0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: got %b want 1", busy);
        end
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1 || sum !== prev_sum) begin
                n_err++;
                $display("FAIL busy_hold lat=%0d: busy=%b sum=%h want busy=1 sum=%h", lat, busy, sum, prev_sum);
            end
            tick;
            lat++;
        end
        n_vec++;
        if (lat !== WIDTH) begin
            n_err++;
            $display("FAIL latency %h+%h: got %0d want %0d", op_a, op_b, lat, WIDTH);
        end
        n_vec++;
        if (sum !== exp_sum || cout !== exp_cout || busy !== 1'b0) begin
            n_err++;
            $display("FAIL result %h+%h: sum=%h cout=%b busy=%b want sum=%h cout=%b busy=0",
                     op_a, op_b, sum, cout, busy, exp_sum, exp_cout);
        end
        tick;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== exp_sum) begin
            n_err++;
            $display("FAIL done_drop: done=%b busy=%b sum=%h want 0 0 %h", done, busy, sum, exp_sum);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) tick;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_quiet cyc=%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_basic_add;
        run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 8'h00);
    endtask

    task automatic test_carry_ripple;
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, 8'hFF);
        run_op(8'hC3, 8'h7E, 8'h41, 1'b1, 8'h00);
    endtask

    task automatic test_start_while_busy;
        int done_cnt;
        int done_at;
        done_cnt = 0; done_at = -1;
        a = 8'h0F; b = 8'h01; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                n_vec++;
                if (sum !== 8'h10 || cout !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_ignore_result: sum=%h cout=%b want 10 0", sum, cout);
                end
            end
            if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (i == 6) start = 1'b0;
        end
        n_vec++;
        if (done_cnt !== 1 || done_at !== WIDTH) begin
            n_err++;
            $display("FAIL busy_ignore_pulses: count=%0d at=%0d want 1 at %0d", done_cnt, done_at, WIDTH);
        end
    endtask

    task automatic test_reset_mid_op;
        a = 8'h80; b = 8'h80; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        n_vec++;
        if (sum !== 8'h10 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort: sum=%h busy=%b want 10 1", sum, busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: sum=%h cout=%b busy=%b done=%b want 00 0 0 0", sum, cout, busy, done);
        end
        repeat (2) tick;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
                n_err++;
                $display("FAIL post_abort cyc=%0d: done=%b busy=%b sum=%h want 0 0 00", i, done, busy, sum);
            end
        end
    endtask

    task automatic test_back_to_back;
        int done_cnt;
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick;
        done_cnt = 0;
        for (int i = 1; i <= 35; i++) begin
            tick;
            if (i % 10 == 8) begin
                n_vec++;
                if (done !== 1'b1 || sum !== 8'h02 || cout !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_done edge=%0d: done=%b sum=%h cout=%b want 1 02 0", i, done, sum, cout);
                end
            end else if (i % 10 == 9) begin
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle edge=%0d: done=%b busy=%b want 0 0", i, done, busy);
                end
            end else if (done !== 1'b0 || busy !== 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL b2b_busy edge=%0d: done=%b busy=%b want 0 1", i, done, busy);
            end
            if (done === 1'b1) done_cnt++;
        end
        start = 1'b0;
        n_vec++;
        if (done_cnt !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 3", done_cnt);
        end
        repeat (12) tick;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h02) begin
            n_err++;
            $display("FAIL b2b_drain: busy=%b done=%b sum=%h want 0 0 02", busy, done, sum);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_basic_add;
        test_carry_ripple;
        test_start_while_busy;
        test_reset_mid_op;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Independent guard: busy and done must never coincide.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_done_overlap at %0t", $time);
        end
    end

endmodule
`default_nettype wire
